// File: rtl/ghost_mover.sv
// ghost_mover: steps a ghost across a grid once per STEP_PERIOD; define GHOST_MOVER_WRAP_EN to wrap edges instead of clamping
module ghost_mover #(
  parameter int GRID_W      = 16,
  parameter int GRID_H      = 12,
  parameter int X_BITS      = 4,
  parameter int Y_BITS      = 4,
  parameter int STEP_PERIOD = 25000000,
  parameter int CNT_BITS    = 25,
  parameter int START_X     = 0,
  parameter int START_Y     = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic [2:0]        dir_in,
  output logic [X_BITS-1:0] pos_x,
  output logic [Y_BITS-1:0] pos_y,
  output logic [2:0]        heading,
  output logic              step_pulse,
  output logic              edge_hit
);
  localparam int XW = X_BITS + 1;
  localparam int YW = Y_BITS + 1;
  typedef enum logic [1:0] {S_IDLE, S_COUNT, S_STEP} state_t;
  state_t              state;
  logic [CNT_BITS-1:0] cnt;
  logic [XW-1:0]       nx;
  logic [YW-1:0]       ny;
  logic                x_inc, x_dec, y_inc, y_dec, x_lo, x_hi, y_lo, y_hi;
  logic [X_BITS-1:0]   x_nxt;
  logic [Y_BITS-1:0]   y_nxt;
  always_comb begin
    x_dec = dir_in <= 3'd2;
    x_inc = dir_in >= 3'd5;
    y_inc = dir_in == 3'd0 || dir_in == 3'd3 || dir_in == 3'd5;
    y_dec = dir_in == 3'd2 || dir_in == 3'd4 || dir_in == 3'd7;
    nx = {1'b0, pos_x} + (x_inc ? XW'(1) : x_dec ? {XW{1'b1}} : XW'(0));
    ny = {1'b0, pos_y} + (y_inc ? YW'(1) : y_dec ? {YW{1'b1}} : YW'(0));
    x_lo = x_dec && nx[X_BITS];
    x_hi = x_inc && nx == XW'(GRID_W);
    y_lo = y_dec && ny[Y_BITS];
    y_hi = y_inc && ny == YW'(GRID_H);
`ifdef GHOST_MOVER_WRAP_EN
    x_nxt = x_lo ? X_BITS'(GRID_W - 1) : x_hi ? '0 : nx[X_BITS-1:0];
    y_nxt = y_lo ? Y_BITS'(GRID_H - 1) : y_hi ? '0 : ny[Y_BITS-1:0];
`else
    x_nxt = (x_lo || x_hi) ? pos_x : nx[X_BITS-1:0];
    y_nxt = (y_lo || y_hi) ? pos_y : ny[Y_BITS-1:0];
`endif
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      cnt        <= '0;
      pos_x      <= X_BITS'(START_X);
      pos_y      <= Y_BITS'(START_Y);
      heading    <= 3'd6;
      step_pulse <= 1'b0;
      edge_hit   <= 1'b0;
    end else begin
      step_pulse <= 1'b0;
      edge_hit   <= 1'b0;
      case (state)
        S_IDLE: begin
          cnt <= '0;
          if (enable) state <= S_COUNT;
        end
        S_COUNT: begin
          if (!enable) begin
            state <= S_IDLE;
            cnt   <= '0;
          end else if (cnt == CNT_BITS'(STEP_PERIOD - 2)) begin
            state <= S_STEP;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CNT_BITS'(1);
          end
        end
        S_STEP: begin
          heading    <= dir_in;
          pos_x      <= x_nxt;
          pos_y      <= y_nxt;
          step_pulse <= 1'b1;
          edge_hit   <= x_lo || x_hi || y_lo || y_hi;
          state      <= enable ? S_COUNT : S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ghost_mover.sv
// tb_ghost_mover: directed checks of step timing, clamp/wrap edges, enable drop and reset
module tb_ghost_mover;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b0;
  logic [2:0] dir_in = 3'd6;
  logic [3:0] pos_x, pos_y;
  logic [2:0] heading;
  logic       step_pulse, edge_hit;
  int         checks = 0;
  int         failures = 0;
  ghost_mover #(.STEP_PERIOD(4), .CNT_BITS(3)) dut (
    .clk(clk), .reset(reset), .enable(enable), .dir_in(dir_in),
    .pos_x(pos_x), .pos_y(pos_y), .heading(heading),
    .step_pulse(step_pulse), .edge_hit(edge_hit)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  task automatic step(input logic [2:0] d, input int en, input int ex, input int ey, input int eh);
    int n;
    dir_in = d;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!step_pulse && n < 50);
    chk("step_delay", n, en);
    chk("pos_x", pos_x, ex);
    chk("pos_y", pos_y, ey);
    chk("heading", heading, d);
    chk("edge_hit", edge_hit, eh);
  endtask
  initial begin
    logic seen;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    chk("rst_x", pos_x, 0);
    chk("rst_y", pos_y, 0);
    chk("rst_heading", heading, 6);
    chk("rst_pulse", step_pulse, 0);
    chk("rst_edge", edge_hit, 0);
    enable = 1'b1;
    step(3'd6, 5, 1, 0, 0);
    step(3'd6, 4, 2, 0, 0);
    step(3'd6, 4, 3, 0, 0);
    step(3'd1, 4, 2, 0, 0);
    step(3'd1, 4, 1, 0, 0);
    step(3'd1, 4, 0, 0, 0);
`ifdef GHOST_MOVER_WRAP_EN
    step(3'd2, 4, 15, 11, 1);
    step(3'd7, 4, 0, 10, 1);
    for (int i = 1; i <= 5; i++) step(3'd6, 4, i, 10, 0);
    for (int i = 1; i <= 4; i++) step(3'd4, 4, 5, 10 - i, 0);
`else
    step(3'd1, 4, 0, 0, 1);
    step(3'd5, 4, 1, 1, 0);
    step(3'd7, 4, 2, 0, 0);
    for (int i = 3; i <= 15; i++) step(3'd6, 4, i, 0, 0);
    step(3'd7, 4, 15, 0, 1);
    step(3'd5, 4, 15, 1, 1);
    for (int i = 1; i <= 5; i++) step(3'd0, 4, 15 - i, 1 + i, 0);
    for (int i = 1; i <= 5; i++) step(3'd1, 4, 10 - i, 6, 0);
`endif
    dir_in = 3'd4;
    @(negedge clk);
    enable = 1'b0;
    @(negedge clk);
    chk("drop_pulse", step_pulse, 0);
    chk("drop_x", pos_x, 5);
    chk("drop_y", pos_y, 6);
    enable = 1'b1;
    step(3'd4, 5, 5, 5, 0);
    @(negedge clk);
    reset = 1'b1;
    enable = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    chk("rerst_x", pos_x, 0);
    chk("rerst_y", pos_y, 0);
    chk("rerst_heading", heading, 6);
    chk("rerst_pulse", step_pulse, 0);
    chk("rerst_edge", edge_hit, 0);
    seen = 1'b0;
    repeat (8) begin
      @(negedge clk);
      seen |= step_pulse;
    end
    chk("idle_no_pulse", seen, 0);
    chk("idle_x", pos_x, 0);
    enable = 1'b1;
    step(3'd3, 5, 0, 1, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
